// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    // Width of the memAck wait counter; covers ACK_TIMEOUT up to 1023.
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // One-hot byte-lane enable for a byte access at the given offset.
    function automatic logic [3:0] byte_lane_en(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-side, data-memory and WB-side signal bundle of the MEM stage.
// slave = the stage itself, master = the surrounding pipeline/memory.
interface mem_stage_if;
    // EX side
    logic        exValid;
    logic        exReady;
    logic [31:0] aluOutput;
    logic [31:0] registerRtOrZero;
    logic        memRead;
    logic        memWrite;
    logic        memByte;
    logic        memSignExt;
    logic [4:0]  destReg;
    logic        regWrite;
    // data memory
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memByteEn;
    logic        memAck;
    logic [31:0] memRdata;
    // WB side
    logic        wbValid;
    logic [31:0] wbData;
    logic [4:0]  wbDest;
    logic        wbRegWrite;
    logic        busError;

    modport slave (
        input  exValid, aluOutput, registerRtOrZero, memRead, memWrite,
               memByte, memSignExt, destReg, regWrite, memAck, memRdata,
        output exReady, memReq, memWe, memAddr, memWdata, memByteEn,
               wbValid, wbData, wbDest, wbRegWrite, busError
    );

    modport master (
        output exValid, aluOutput, registerRtOrZero, memRead, memWrite,
               memByte, memSignExt, destReg, regWrite, memAck, memRdata,
        input  exReady, memReq, memWe, memAddr, memWdata, memByteEn,
               wbValid, wbData, wbDest, wbRegWrite, busError
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte out of a read word and extends it,
// or passes the whole word through for word accesses.
module load_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic        byte_i,
    input  logic        sign_ext_i,
    output logic [31:0] result_o
);

    logic [7:0] sel;

    // Lane select, then sign/zero extension for byte loads.
    always_comb begin
        case (offset_i)
            2'd0:    sel = rdata_i[7:0];
            2'd1:    sel = rdata_i[15:8];
            2'd2:    sel = rdata_i[23:16];
            default: sel = rdata_i[31:24];
        endcase
        if (byte_i) begin
            result_o = {{24{sign_ext_i & sel[7]}}, sel};
        end else begin
            result_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle, runs loads and
// stores against a req/ack data memory with an ack timeout, and flags
// misaligned word accesses. Byte loads/stores are built only when
// MEM_STAGE_BYTE_ACCESS_EN is defined; otherwise memByte is ignored.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);

    // Timeout fires on the edge that would bring the counter to ACK_TIMEOUT.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             memReq_q, memReq_d;
    logic             memWe_q, memWe_d;
    logic [31:0]      memAddr_q, memAddr_d;
    logic [31:0]      memWdata_q, memWdata_d;
    logic [3:0]       memByteEn_q, memByteEn_d;
    logic             wbValid_q, wbValid_d;
    logic [31:0]      wbData_q, wbData_d;
    logic [4:0]       wbDest_q, wbDest_d;
    logic             wbRegWrite_q, wbRegWrite_d;
    logic             busError_q, busError_d;
    // Context of the in-flight memory op, needed when the ack arrives.
    logic [1:0]       ldOffset_q, ldOffset_d;
    logic             ldByte_q, ldByte_d;
    logic             ldSignExt_q, ldSignExt_d;
    logic             isLoad_q, isLoad_d;
    logic [4:0]       pendDest_q, pendDest_d;
    logic             pendRegWr_q, pendRegWr_d;

    logic             byteSel;
    logic             accept;
    logic             isMem;
    logic             misaligned;
    logic [31:0]      loadData;

`ifdef MEM_STAGE_BYTE_ACCESS_EN
    assign byteSel = bus.memByte;
`else
    logic unusedByte;
    assign byteSel    = 1'b0;
    assign unusedByte = bus.memByte;
`endif

    assign accept     = bus.exValid && (state_q == IDLE);
    assign isMem      = bus.memRead || bus.memWrite;
    assign misaligned = !byteSel && (bus.aluOutput[1:0] != 2'b00);

    load_align u_align (
        .rdata_i    (bus.memRdata),
        .offset_i   (ldOffset_q),
        .byte_i     (ldByte_q),
        .sign_ext_i (ldSignExt_q),
        .result_o   (loadData)
    );

    // State and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            memByteEn_q  <= BE_NONE;
            wbValid_q    <= 1'b0;
            wbData_q     <= '0;
            wbDest_q     <= '0;
            wbRegWrite_q <= 1'b0;
            busError_q   <= 1'b0;
            ldOffset_q   <= '0;
            ldByte_q     <= 1'b0;
            ldSignExt_q  <= 1'b0;
            isLoad_q     <= 1'b0;
            pendDest_q   <= '0;
            pendRegWr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            memReq_q     <= memReq_d;
            memWe_q      <= memWe_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            memByteEn_q  <= memByteEn_d;
            wbValid_q    <= wbValid_d;
            wbData_q     <= wbData_d;
            wbDest_q     <= wbDest_d;
            wbRegWrite_q <= wbRegWrite_d;
            busError_q   <= busError_d;
            ldOffset_q   <= ldOffset_d;
            ldByte_q     <= ldByte_d;
            ldSignExt_q  <= ldSignExt_d;
            isLoad_q     <= isLoad_d;
            pendDest_q   <= pendDest_d;
            pendRegWr_q  <= pendRegWr_d;
        end
    end

    // Next-state and registered-output logic; WB strobes default to a pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        memReq_d     = memReq_q;
        memWe_d      = memWe_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        memByteEn_d  = memByteEn_q;
        wbValid_d    = 1'b0;
        wbData_d     = wbData_q;
        wbDest_d     = wbDest_q;
        wbRegWrite_d = 1'b0;
        busError_d   = 1'b0;
        ldOffset_d   = ldOffset_q;
        ldByte_d     = ldByte_q;
        ldSignExt_d  = ldSignExt_q;
        isLoad_d     = isLoad_q;
        pendDest_d   = pendDest_q;
        pendRegWr_d  = pendRegWr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!isMem) begin
                        wbValid_d    = 1'b1;
                        wbData_d     = bus.aluOutput;
                        wbDest_d     = bus.destReg;
                        wbRegWrite_d = bus.regWrite;
                    end else if (misaligned) begin
                        wbValid_d  = 1'b1;
                        wbData_d   = '0;
                        wbDest_d   = bus.destReg;
                        busError_d = 1'b1;
                    end else begin
                        // memWrite wins when both read and write are set.
                        state_d     = WAIT;
                        cnt_d       = '0;
                        memReq_d    = 1'b1;
                        memWe_d     = bus.memWrite;
                        memAddr_d   = {bus.aluOutput[31:2], 2'b00};
                        memWdata_d  = byteSel ? {4{bus.registerRtOrZero[7:0]}}
                                              : bus.registerRtOrZero;
                        memByteEn_d = byteSel ? byte_lane_en(bus.aluOutput[1:0])
                                              : BE_WORD;
                        ldOffset_d  = bus.aluOutput[1:0];
                        ldByte_d    = byteSel;
                        ldSignExt_d = bus.memSignExt;
                        isLoad_d    = !bus.memWrite;
                        pendDest_d  = bus.destReg;
                        pendRegWr_d = bus.regWrite;
                    end
                end
            end
            WAIT: begin
                if (bus.memAck) begin
                    state_d      = RESP;
                    memReq_d     = 1'b0;
                    wbValid_d    = 1'b1;
                    wbDest_d     = pendDest_q;
                    wbData_d     = isLoad_q ? loadData : '0;
                    wbRegWrite_d = pendRegWr_q && isLoad_q;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = RESP;
                    memReq_d   = 1'b0;
                    busError_d = 1'b1;
                    wbValid_d  = 1'b1;
                    wbDest_d   = pendDest_q;
                    wbData_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.exReady    = (state_q == IDLE);
    assign bus.memReq     = memReq_q;
    assign bus.memWe      = memWe_q;
    assign bus.memAddr    = memAddr_q;
    assign bus.memWdata   = memWdata_q;
    assign bus.memByteEn  = memByteEn_q;
    assign bus.wbValid    = wbValid_q;
    assign bus.wbData     = wbData_q;
    assign bus.wbDest     = wbDest_q;
    assign bus.wbRegWrite = wbRegWrite_q;
    assign bus.busError   = busError_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage (ACK_TIMEOUT=4). Honours
// MEM_STAGE_BYTE_ACCESS_EN to pick the matching reference behaviour.
module tb_mem_stage;

    localparam int TO = 4;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    localparam bit BYTE_BUILD = 1'b1;
`else
    localparam bit BYTE_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage #(.ACK_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        expQ[$];
    req_t        reqQ[$];
    logic [31:0] refMem [256];
    logic [31:0] dutMem [256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          monEn = 1'b0;
    bit          respEn = 1'b0;
    logic        manualAck = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_memReq"}, 32'(bus.memReq), 0);
        chk({tag, "_memWe"}, 32'(bus.memWe), 0);
        chk({tag, "_memAddr"}, bus.memAddr, 0);
        chk({tag, "_memWdata"}, bus.memWdata, 0);
        chk({tag, "_memByteEn"}, 32'(bus.memByteEn), 0);
        chk({tag, "_wbValid"}, 32'(bus.wbValid), 0);
        chk({tag, "_wbData"}, bus.wbData, 0);
        chk({tag, "_wbDest"}, 32'(bus.wbDest), 0);
        chk({tag, "_wbRegWrite"}, 32'(bus.wbRegWrite), 0);
        chk({tag, "_busError"}, 32'(bus.busError), 0);
        chk({tag, "_exReady"}, 32'(bus.exReady), 1);
    endtask

    // Byte extraction by shifting the word, per the load rules.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                               input bit bm, input bit sx);
        logic [31:0] b;
        if (!bm) return word;
        b = (word >> (8 * off)) & 32'hFF;
        if (sx && b >= 32'h80) b = b | 32'hFFFF_FF00;
        return b;
    endfunction

    // kind: 0 ALU, 1 load, 2 store, 3 read+write (acts as store)
    task automatic send(input int kind, input logic [31:0] alu, input logic [31:0] rt,
                        input bit bmIn, input bit sx, input logic [4:0] dest,
                        input bit rw, input int delay);
        exp_t e;
        req_t r;
        int   guard;
        int   c;
        int   off;
        int   idx;
        bit   bm;
        bit   isStore;
        bit   timedOut;
        logic [31:0] w;
        guard = 0;
        @(negedge clk);
        while (bus.exReady !== 1'b1) begin
            guard++;
            if (guard > 50) begin
                total++; bad++;
                $display("FAIL exReady_wait: got %b want 1 after %0d cycles", bus.exReady, guard);
                return;
            end
            @(negedge clk);
        end
        bus.exValid          = 1'b1;
        bus.aluOutput        = alu;
        bus.registerRtOrZero = rt;
        bus.memRead          = (kind == 1 || kind == 3);
        bus.memWrite         = (kind >= 2);
        bus.memByte          = bmIn;
        bus.memSignExt       = sx;
        bus.destReg          = dest;
        bus.regWrite         = rw;
        c = cyc;
        e.dest = dest;
        if (kind == 0) begin
            e.data = alu; e.rw = rw; e.err = 1'b0; e.cyc = c + 1;
        end else begin
            isStore = (kind >= 2);
            bm  = BYTE_BUILD && bmIn;
            off = int'(alu[1:0]);
            idx = int'(alu[9:2]);
            if (!bm && off != 0) begin
                e.data = 0; e.rw = 1'b0; e.err = 1'b1; e.cyc = c + 1;
            end else begin
                r.addr  = alu & 32'hFFFF_FFFC;
                r.we    = isStore;
                r.be    = bm ? 4'(1 << off) : 4'hF;
                r.wdata = bm ? {4{rt[7:0]}} : rt;
                r.delay = delay;
                reqQ.push_back(r);
                timedOut = (delay >= TO);
                e.err = timedOut;
                e.cyc = timedOut ? c + 1 + TO : c + 2 + delay;
                if (isStore) begin
                    e.data = 0; e.rw = 1'b0;
                    if (!timedOut) begin
                        if (bm) begin
                            w = refMem[idx] & ~(32'hFF << (8 * off));
                            refMem[idx] = w | ({24'd0, rt[7:0]} << (8 * off));
                        end else begin
                            refMem[idx] = rt;
                        end
                    end
                end else begin
                    e.data = timedOut ? 32'h0 : model_load(refMem[idx], off, bm, sx);
                    e.rw   = timedOut ? 1'b0 : rw;
                end
            end
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        bus.exValid = 1'b0;
    endtask

    // Memory device: checks each request against the queued expectation and
    // acks after the chosen delay; throws stray acks while idle.
    initial begin : responder
        bit   active;
        int   wcnt;
        req_t cur;
        active = 1'b0;
        wcnt = 0;
        bus.memAck = 1'b0;
        bus.memRdata = '0;
        forever begin
            @(negedge clk);
            bus.memRdata = $urandom;
            if (!respEn) begin
                bus.memAck = manualAck;
                active = 1'b0;
                continue;
            end
            bus.memAck = 1'b0;
            if (bus.memReq === 1'b1) begin
                if (!active) begin
                    if (reqQ.size() == 0) begin
                        total++; bad++;
                        $display("FAIL memReq_unexpected: got memReq=1 want 0 (cycle %0d)", cyc);
                    end else begin
                        cur = reqQ.pop_front();
                        active = 1'b1;
                        wcnt = 0;
                    end
                end
                if (active) begin
                    chk("memAddr", bus.memAddr, cur.addr);
                    chk("memWe", 32'(bus.memWe), 32'(cur.we));
                    chk("memByteEn", 32'(bus.memByteEn), 32'(cur.be));
                    if (cur.we) chk("memWdata", bus.memWdata, cur.wdata);
                    chk("exReady_in_wait", 32'(bus.exReady), 0);
                    if (wcnt == cur.delay) begin
                        bus.memAck = 1'b1;
                        bus.memRdata = dutMem[bus.memAddr[9:2]];
                        if (bus.memWe) begin
                            for (int k = 0; k < 4; k++)
                                if (bus.memByteEn[k])
                                    dutMem[bus.memAddr[9:2]][8*k +: 8] = bus.memWdata[8*k +: 8];
                        end
                        active = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                active = 1'b0;
                if ($urandom_range(0, 5) == 0) bus.memAck = 1'b1;
            end
        end
    end

    // WB monitor: every wbValid pulse must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!monEn) continue;
            if (bus.wbValid !== 1'b0) begin
                if (expQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wbValid_unexpected: got %b want 0 (cycle %0d)", bus.wbValid, cyc);
                end else begin
                    e = expQ.pop_front();
                    chk("wbData", bus.wbData, e.data);
                    chk("wbDest", 32'(bus.wbDest), 32'(e.dest));
                    chk("wbRegWrite", 32'(bus.wbRegWrite), 32'(e.rw));
                    chk("busError", 32'(bus.busError), 32'(e.err));
                    chk("wb_cycle", cyc, e.cyc);
                end
            end else if (bus.busError !== 1'b0) begin
                chk("busError_alone", 32'(bus.busError), 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          kind;
        int          delay;
        int          guard;
        logic [31:0] a;
        rst_n = 1'b0;
        bus.exValid = 1'b0;
        bus.aluOutput = '0;
        bus.registerRtOrZero = '0;
        bus.memRead = 1'b0;
        bus.memWrite = 1'b0;
        bus.memByte = 1'b0;
        bus.memSignExt = 1'b0;
        bus.destReg = '0;
        bus.regWrite = 1'b0;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = $urandom;
            dutMem[i] = refMem[i];
        end
        refMem[32'h100 >> 2] = 32'hDEAD_BEEF; dutMem[32'h100 >> 2] = 32'hDEAD_BEEF;
        refMem[32'h200 >> 2] = 32'h80FF_FFFF; dutMem[32'h200 >> 2] = 32'h80FF_FFFF;

        repeat (3) @(posedge clk);
        #1 chk_quiet("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("exReady_after_reset", 32'(bus.exReady), 1);
        respEn = 1'b1;
        monEn = 1'b1;

        // Directed cases
        send(0, 32'h1234, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1, 0);
        send(1, 32'h100, 32'h0, 1'b0, 1'b0, 5'd3, 1'b1, 3);
        send(2, 32'h102, 32'hCAFE, 1'b0, 1'b0, 5'd4, 1'b1, 0);
        send(1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd6, 1'b1, 99);
        send(1, 32'h203, 32'h0, 1'b1, 1'b1, 5'd7, 1'b1, 0);
        send(1, 32'h203, 32'h0, 1'b1, 1'b0, 5'd8, 1'b1, 2);
        send(1, 32'h104, 32'h0, 1'b0, 1'b0, 5'd9, 1'b1, TO - 1);
        send(3, 32'h108, 32'h55AA, 1'b0, 1'b0, 5'd10, 1'b1, 1);
        send(1, 32'h108, 32'h0, 1'b0, 1'b0, 5'd11, 1'b1, 0);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 4) ? 0 : (kind < 7) ? 1 : (kind < 9) ? 2 : 3;
            if (kind == 0) begin
                a = $urandom;
            end else begin
                a = 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            end
            delay = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(kind, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), delay);
        end

        // Drain outstanding responses
        guard = 0;
        while (expQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(expQ.size()), 0);

        // Reset in the middle of WAIT, then a late ack
        @(posedge clk);
        #1 respEn = 1'b0;
        manualAck = 1'b0;
        @(negedge clk);
        bus.exValid = 1'b1;
        bus.aluOutput = 32'h40;
        bus.memRead = 1'b1;
        bus.memWrite = 1'b0;
        bus.memByte = 1'b0;
        @(posedge clk);
        #1 bus.exValid = 1'b0;
        bus.memRead = 1'b0;
        chk("rstwait_memReq", 32'(bus.memReq), 1);
        chk("rstwait_memAddr", bus.memAddr, 32'h40);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 manualAck = 1'b1;
        @(posedge clk);
        #1 manualAck = 1'b0;
        chk_quiet("post_reset");
        repeat (5) @(posedge clk);
        #1 chk_quiet("post_reset_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 255, the number of cycles a memory request may wait for memAck before abort (legal range 1..1023).
Ports:
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have these EX-side ports: exValid in 1, EX result present; exReady out 1, stage can accept.
REQ-005 The block SHALL have these EX-side ports: aluOutput in 32, memory address or ALU result; registerRtOrZero in 32, store data.
REQ-006 The block SHALL have these EX-side ports, each input 1 bit: memRead, load; memWrite, store; memByte, byte access; memSignExt, sign-extend loaded byte.
REQ-007 The block SHALL have these EX-side ports: destReg in 5, destination register; regWrite in 1, writeback enable.
REQ-008 The block SHALL have these data-memory ports: memReq out 1, request; memWe out 1, write; memAddr out 32, word-aligned address; memWdata out 32; memByteEn out 4, byte lane enables.
REQ-009 The block SHALL have these data-memory ports: memAck in 1, request complete; memRdata in 32, read data.
REQ-010 The block SHALL have these WB-side outputs: wbValid 1, result valid; wbData 32; wbDest 5; wbRegWrite 1.
REQ-011 The block SHALL have output busError, 1 bit, a one-cycle pulse on timeout or misaligned access.

Function
REQ-012 The block SHALL accept an EX transfer on a cycle where exValid and exReady are both 1.
REQ-013 The block SHALL implement states IDLE, WAIT and RESP.
REQ-014 In IDLE, for an accepted non-memory op (memRead=memWrite=0), the block SHALL stay in IDLE and present wbValid=1, wbData=aluOutput, wbDest=destReg, wbRegWrite=regWrite on the next cycle; latency 1, throughput 1/cycle.
REQ-015 For an accepted memory op, the block SHALL enter WAIT and assert memReq from the next cycle.
REQ-016 While in WAIT, the block SHALL hold memReq, memWe, memAddr, memWdata and memByteEn stable and hold exReady=0.
REQ-017 If memRead and memWrite are both 1 on acceptance, the block SHALL treat the op as a store.
REQ-018 memAddr SHALL be {aluOutput[31:2],2'b00}; memByteEn SHALL be 4'b1111 for word access.
REQ-019 On memAck=1 in WAIT, the block SHALL deassert memReq on the next cycle and go to RESP.
REQ-020 In RESP, the block SHALL pulse wbValid for one cycle with wbData = the aligned load result, or 0 for a store.
REQ-021 In RESP, wbRegWrite SHALL equal regWrite AND memRead; the block SHALL return to IDLE with exReady=1.
REQ-022 Memory latency SHALL be (ack cycle - request cycle) + 2 from acceptance to wbValid.
REQ-023 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle without memAck.
REQ-024 When the counter reaches ACK_TIMEOUT, the block SHALL drop memReq, pulse busError, and go to RESP with wbRegWrite=0 and wbData=0.
REQ-025 memAck arriving on the same cycle the timeout is reached SHALL win: normal completion, no busError.
REQ-026 A word access with aluOutput[1:0]!=0 SHALL issue no request, pulse busError and give wbValid next cycle with wbRegWrite=0.
REQ-027 memAck outside WAIT SHALL be ignored.
REQ-028 wbValid SHALL be a single-cycle pulse per accepted op; WB is always ready.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, clear the counter and set memReq=0, memWe=0, memAddr=0, memWdata=0, memByteEn=0, wbValid=0, wbData=0, wbDest=0, wbRegWrite=0, busError=0; exReady SHALL be 1 on the first cycle after reset release.
REQ-030 Reset during WAIT SHALL abandon the request without busError; a later memAck SHALL be ignored.

Configuration
REQ-031 With MEM_STAGE_BYTE_ACCESS_EN defined, memByte=1 SHALL select byte lane aluOutput[1:0] with one-hot memByteEn, replicate registerRtOrZero[7:0] into all four memWdata bytes, and return the selected byte sign- or zero-extended per memSignExt; byte accesses are never misaligned.
REQ-032 Without MEM_STAGE_BYTE_ACCESS_EN, memByte SHALL be ignored and every access SHALL be word access.

Structure
REQ-033 The shared package mem_stage_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the byte-enable constants and the counter width (10 bits).
REQ-034 Byte selection and extension SHALL be one sub-module, load_align (inputs rdata, offset, byte, signExt; output 32-bit result).

Verification
REQ-035 ALU op, aluOutput=0x1234, regWrite=1, destReg=5 -> next cycle wbValid=1, wbData=0x1234, wbDest=5, no memReq.
REQ-036 Word load at 0x100, memAck 3 cycles after memReq, memRdata=0xDEADBEEF -> memAddr=0x100, exReady=0 throughout, wbData=0xDEADBEEF, wbRegWrite=1.
REQ-037 Word store at 0x102 -> no memReq, busError pulse, wbRegWrite=0.
REQ-038 ACK_TIMEOUT=4, load never acked -> memReq drops after 4 WAIT cycles, busError=1 for one cycle, wbRegWrite=0.
REQ-039 Byte build, signed lb at 0x203, memRdata=0x80FFFFFF -> memByteEn=4'b1000, wbData=0xFFFFFF80; with memSignExt=0 -> 0x00000080.
REQ-040 rst_n low two cycles into WAIT, then memAck -> after reset all outputs 0, exReady=1, no wbValid.
